// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake,
// holds each word for decode and resolves branch/JAL/JALR redirects.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [1:0]      redirect_kind,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic            inst_valid,
    output logic            misalign_err
);

    // state   | meaning
    // S_BOOT  | one idle cycle after reset
    // S_FETCH | request outstanding at pc, waiting for imem_ready
    // S_HOLD  | instruction presented to decode
    // S_HALT  | misaligned redirect seen; wait for reset
    typedef enum logic [1:0] {
        S_BOOT,
        S_FETCH,
        S_HOLD,
        S_HALT
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] target;

    assign imem_addr = pc;
    assign pc_plus4  = inst_pc + 32'd4;
    assign jalr_sum  = rs1_data + imm;

    // Reserved kind falls back to sequential flow.
    always_comb begin
        target = pc_plus4;
        if (redirect_valid) begin
            case (redirect_kind)
                2'b00, 2'b01: target = inst_pc + imm;
                2'b10:        target = {jalr_sum[XLEN-1:1], 1'b0};
                default:      target = pc_plus4;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_BOOT;
            pc           <= RESET_PC;
            imem_req     <= 1'b0;
            inst         <= '0;
            inst_pc      <= RESET_PC;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        inst       <= imem_rdata;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        imem_req   <= 1'b0;
                        state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        inst_valid <= 1'b0;
                        if (target[1:0] != 2'b00) begin
                            misalign_err <= 1'b1;
                            state        <= S_HALT;
                        end else begin
                            pc       <= target;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    imem_req   <= 1'b0;
                    inst_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus a randomized
// fetch/stall/redirect stream checked against a transaction-level PC model.
module tb_fetch_pc_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [1:0]  redirect_kind = 2'b00;
    logic [31:0] imm = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] pc_plus4;
    logic        inst_valid;
    logic        misalign_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_pc;

    fetch_pc_unit #(.RESET_PC(RESET_PC), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall(stall), .redirect_valid(redirect_valid),
        .redirect_kind(redirect_kind), .imm(imm), .rs1_data(rs1_data),
        .inst(inst), .inst_pc(inst_pc), .pc_plus4(pc_plus4),
        .inst_valid(inst_valid), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Spec-level next-PC rule for a held instruction being released.
    function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic rv,
                                               input logic [1:0] kind, input logic [31:0] im,
                                               input logic [31:0] rs1);
        logic [31:0] s;
        if (!rv || kind == 2'd3) return ipc + 32'd4;
        if (kind == 2'd2) begin
            s = rs1 + im;
            s[0] = 1'b0;
            return s;
        end
        return ipc + im;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        exp_pc = RESET_PC;
    endtask

    task automatic fetch_one(input int waits, input logic [31:0] word, input logic [31:0] addr);
        int t = 0;
        while (!imem_req && t < 20) begin
            step();
            t++;
        end
        n_cmp++;
        if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL req_timeout: imem_req=%b required 1", imem_req);
        end
        n_cmp++;
        if (imem_addr !== addr) begin
            n_err++; $display("FAIL fetch_addr: got %h required %h", imem_addr, addr);
        end
        for (int i = 0; i < waits; i++) begin
            step();
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== addr || inst_valid !== 1'b0) begin
                n_err++;
                $display("FAIL wait_hold: req=%b addr=%h valid=%b required 1/%h/0",
                         imem_req, imem_addr, inst_valid, addr);
            end
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        n_cmp++;
        if (inst_valid !== 1'b1 || inst !== word || inst_pc !== addr || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL capture: valid=%b inst=%h pc=%h req=%b required 1/%h/%h/0",
                     inst_valid, inst, inst_pc, imem_req, word, addr);
        end
        n_cmp++;
        if (pc_plus4 !== addr + 32'd4) begin
            n_err++; $display("FAIL pc_plus4: got %h required %h", pc_plus4, addr + 32'd4);
        end
    endtask

    task automatic release_hold(input int stalls, input logic rv, input logic [1:0] kind,
                                input logic [31:0] im, input logic [31:0] rs1,
                                input logic [31:0] ipc, input logic [31:0] word,
                                output bit halted);
        logic [31:0] tgt;
        for (int i = 0; i < stalls; i++) begin
            stall = 1'b1;
            redirect_valid = 1'b1;
            redirect_kind = 2'($urandom_range(0, 3));
            imm = $urandom;
            rs1_data = $urandom;
            imem_ready = 1'b1;
            imem_rdata = $urandom;
            step();
            n_cmp++;
            if (inst !== word || inst_pc !== ipc || inst_valid !== 1'b1 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: inst=%h pc=%h valid=%b req=%b required %h/%h/1/0",
                         inst, inst_pc, inst_valid, imem_req, word, ipc);
            end
        end
        stall = 1'b0;
        imem_ready = 1'b0;
        redirect_valid = rv;
        redirect_kind = kind;
        imm = im;
        rs1_data = rs1;
        step();
        redirect_valid = 1'b0;
        tgt = model_next(ipc, rv, kind, im, rs1);
        halted = (tgt[1:0] != 2'b00);
        n_cmp++;
        if (inst_valid !== 1'b0) begin
            n_err++; $display("FAIL release_valid: got %b required 0", inst_valid);
        end
        n_cmp++;
        if (halted) begin
            if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL halt_entry: misalign=%b req=%b required 1/0", misalign_err, imem_req);
            end
        end else begin
            if (imem_req !== 1'b1 || imem_addr !== tgt || misalign_err !== 1'b0) begin
                n_err++;
                $display("FAIL next_fetch: req=%b addr=%h misalign=%b required 1/%h/0",
                         imem_req, imem_addr, misalign_err, tgt);
            end
            exp_pc = tgt;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 ||
            inst_pc !== RESET_PC || misalign_err !== 1'b0 || imem_addr !== RESET_PC) begin
            n_err++;
            $display("FAIL reset_state: req=%b valid=%b inst=%h pc=%h mis=%b addr=%h",
                     imem_req, inst_valid, inst, inst_pc, misalign_err, imem_addr);
        end
        step();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            n_err++; $display("FAIL boot_req: req=%b addr=%h required 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_zero_wait();
        bit h;
        fetch_one(0, 32'h0000_0013, 32'h0);
        release_hold(0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0000_0013, h);
    endtask

    task automatic test_wait_states();
        bit h;
        fetch_one(0, 32'h1111_1111, 32'h4);
        release_hold(0, 1'b0, 2'b00, 32'h0, 32'h0, 32'h4, 32'h1111_1111, h);
        fetch_one(3, 32'h2222_2222, 32'h8);
        release_hold(0, 1'b1, 2'b01, 32'h38, 32'h0, 32'h8, 32'h2222_2222, h);
    endtask

    task automatic test_branch_stall();
        bit h;
        fetch_one(1, 32'hFE00_0EE3, 32'h40);
        release_hold(2, 1'b1, 2'b00, 32'hFFFF_FFF0, 32'h0, 32'h40, 32'hFE00_0EE3, h);
    endtask

    task automatic test_jalr();
        bit h;
        fetch_one(0, 32'h0040_8067, 32'h30);
        release_hold(0, 1'b1, 2'b10, 32'h4, 32'h1001, 32'h30, 32'h0040_8067, h);
        fetch_one(2, 32'h0000_0000, 32'h1004);
        release_hold(1, 1'b1, 2'b11, 32'h100, 32'h0, 32'h1004, 32'h0, h);
    endtask

    task automatic test_misalign();
        bit h;
        fetch_one(0, 32'h0000_0067, 32'h1008);
        release_hold(0, 1'b1, 2'b10, 32'h0, 32'h100, 32'h1008, 32'h0000_0067, h);
        fetch_one(0, 32'h0020_006F, 32'h100);
        release_hold(0, 1'b1, 2'b01, 32'h2, 32'h0, 32'h100, 32'h0020_006F, h);
        n_cmp++;
        if (!h) begin
            n_err++; $display("FAIL misalign_model: halted=%0d required 1", h);
        end
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (imem_req !== 1'b0 || inst_valid !== 1'b0 || misalign_err !== 1'b1) begin
                n_err++;
                $display("FAIL halt_stay: req=%b valid=%b mis=%b required 0/0/1",
                         imem_req, inst_valid, misalign_err);
            end
        end
        do_reset();
        n_cmp++;
        if (misalign_err !== 1'b0) begin
            n_err++; $display("FAIL misalign_clear: got %b required 0", misalign_err);
        end
        fetch_one(0, 32'h0000_0013, RESET_PC);
    endtask

    task automatic test_wrap();
        bit h;
        release_hold(0, 1'b1, 2'b10, 32'hFFFF_FFFC, 32'h0, RESET_PC, 32'h0000_0013, h);
        fetch_one(1, 32'hAAAA_5555, 32'hFFFF_FFFC);
        release_hold(0, 1'b0, 2'b00, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'hAAAA_5555, h);
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_err++; $display("FAIL wrap_addr: got %h required 00000000", imem_addr);
        end
    endtask

    task automatic test_reset_mid_fetch();
        n_cmp++;
        if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL pre_rst_req: got %b required 1", imem_req);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL rst_mid_fetch: req=%b valid=%b required 0/0", imem_req, inst_valid);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ready = 1'b0;
        step();
        n_cmp++;
        if (inst_valid !== 1'b0 || inst === 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL late_ready: valid=%b inst=%h required 0/not deadbeef", inst_valid, inst);
        end
        exp_pc = RESET_PC;
        fetch_one(0, 32'h0000_0093, RESET_PC);
    endtask

    task automatic test_random();
        bit h;
        logic [31:0] word, im, rs1, ipc;
        logic [1:0] kind;
        logic rv;
        for (int n = 0; n < 60; n++) begin
            word = $urandom;
            ipc = exp_pc;
            if (n > 0) fetch_one($urandom_range(0, 3), word, ipc);
            else word = 32'h0000_0093;
            rv = 1'($urandom_range(0, 1));
            kind = 2'($urandom_range(0, 3));
            im = $urandom;
            if ($urandom_range(0, 3) != 0) im[1:0] = 2'b00;
            rs1 = $urandom;
            release_hold($urandom_range(0, 2), rv, kind, im, rs1, ipc, word, h);
            if (h) begin
                do_reset();
                step();
            end
        end
    endtask

    initial begin
        exp_pc = RESET_PC;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_branch_stall();
        test_jalr();
        test_misalign();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
